// File: rtl/dtcm_arbiter.sv
// Two-port round-robin arbiter in front of the data TCM, with a bounded
// port-1 bus lock and registered, funct3-extended read responses.
module dtcm_arbiter #(
   parameter int unsigned AW       = 4,
   parameter int unsigned DW       = 32,
   parameter int unsigned LOCK_MAX = 8
) (
   input  logic          CLK,
   input  logic          RSTN,
   input  logic          P0_REQ,
   input  logic          P0_WE,
   input  logic [AW-1:0] P0_ADDR,
   input  logic [DW-1:0] P0_WDATA,
   input  logic [2:0]    P0_TYPE,
   input  logic          P1_REQ,
   input  logic          P1_WE,
   input  logic [AW-1:0] P1_ADDR,
   input  logic [DW-1:0] P1_WDATA,
   input  logic [2:0]    P1_TYPE,
   input  logic          P1_LOCK,
   output logic          P0_GNT,
   output logic          P1_GNT,
   output logic          P0_RVALID,
   output logic          P1_RVALID,
   output logic [DW-1:0] P0_RDATA,
   output logic [DW-1:0] P1_RDATA,
   output logic [AW-1:0] M_WADDR,
   output logic [AW-1:0] M_RADDR,
   output logic [DW-1:0] M_WDATA,
   output logic          M_WEN,
   output logic          M_REN,
   output logic [2:0]    M_RW_TYPE,
   input  logic [DW-1:0] M_RDATA
);

   typedef enum logic [1:0] {
      ST_ARB    = 2'd0,
      ST_LOCKED = 2'd1,
      ST_YIELD  = 2'd2
   } state_t;

   localparam logic [7:0] LOCK_LAST = 8'(LOCK_MAX - 1);

   state_t          state_r;
   logic            last_r;
   logic [7:0]      cnt_r;
   logic            gnt0_s;
   logic            gnt1_s;
   logic            any_gnt_s;
   logic            sel_we_s;
   logic [AW-1:0]   sel_addr_s;
   logic [DW-1:0]   sel_wdata_s;
   logic [2:0]      sel_type_s;
   logic            p0_rvalid_r;
   logic            p1_rvalid_r;
   logic [DW-1:0]   p0_rdata_r;
   logic [DW-1:0]   p1_rdata_r;

   // RISC-V load extension of the raw memory word according to funct3.
   function automatic logic [DW-1:0] ext_rdata(input logic [2:0] t, input logic [DW-1:0] d);
      logic [DW-1:0] r;
      case (t)
         3'b000:  r = {{(DW-8){d[7]}}, d[7:0]};
         3'b001:  r = {{(DW-16){d[15]}}, d[15:0]};
         3'b100:  r = {{(DW-8){1'b0}}, d[7:0]};
         3'b101:  r = {{(DW-16){1'b0}}, d[15:0]};
         default: r = d;
      endcase
      return r;
   endfunction

   // Grant selection: round-robin in ARB, port 1 only in LOCKED, port 0 first in YIELD.
   always_comb begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
      case (state_r)
         ST_ARB: begin
            gnt0_s = P0_REQ & (~P1_REQ | last_r);
            gnt1_s = P1_REQ & (~P0_REQ | ~last_r);
         end
         ST_LOCKED: begin
            gnt0_s = 1'b0;
            gnt1_s = P1_REQ;
         end
         ST_YIELD: begin
            gnt0_s = P0_REQ;
            gnt1_s = P1_REQ & ~P0_REQ;
         end
         default: begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
         end
      endcase
   end

   // Memory-side mux from the granted port; everything is zero when idle.
   always_comb begin
      sel_we_s    = 1'b0;
      sel_addr_s  = {AW{1'b0}};
      sel_wdata_s = {DW{1'b0}};
      sel_type_s  = 3'b000;
      if (gnt0_s) begin
         sel_we_s    = P0_WE;
         sel_addr_s  = P0_ADDR;
         sel_wdata_s = P0_WDATA;
         sel_type_s  = P0_TYPE;
      end else if (gnt1_s) begin
         sel_we_s    = P1_WE;
         sel_addr_s  = P1_ADDR;
         sel_wdata_s = P1_WDATA;
         sel_type_s  = P1_TYPE;
      end else begin
         sel_we_s    = 1'b0;
         sel_addr_s  = {AW{1'b0}};
         sel_wdata_s = {DW{1'b0}};
         sel_type_s  = 3'b000;
      end
   end

   assign any_gnt_s = gnt0_s | gnt1_s;
   assign P0_GNT    = gnt0_s;
   assign P1_GNT    = gnt1_s;
   assign M_WEN     = any_gnt_s & sel_we_s;
   assign M_REN     = any_gnt_s & ~sel_we_s;
   assign M_WADDR   = M_WEN ? sel_addr_s : {AW{1'b0}};
   assign M_RADDR   = M_REN ? sel_addr_s : {AW{1'b0}};
   assign M_WDATA   = M_WEN ? sel_wdata_s : {DW{1'b0}};
   assign M_RW_TYPE = sel_type_s;

   // Arbitration FSM, round-robin history and lock-length counter.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_r <= ST_ARB;
         last_r  <= 1'b1;
         cnt_r   <= 8'd0;
      end else begin
         if (gnt0_s) begin
            last_r <= 1'b0;
         end else if (gnt1_s) begin
            last_r <= 1'b1;
         end else begin
            last_r <= last_r;
         end
         case (state_r)
            ST_ARB: begin
               if (gnt1_s && P1_LOCK) begin
                  state_r <= ST_LOCKED;
                  cnt_r   <= 8'd0;
               end
            end
            ST_LOCKED: begin
               if (!P1_LOCK) begin
                  state_r <= ST_ARB;
               end else if (cnt_r == LOCK_LAST) begin
                  state_r <= ST_YIELD;
               end else begin
                  cnt_r <= cnt_r + 8'd1;
               end
            end
            ST_YIELD: begin
               // The lock request is ignored here so port 0 always gets its slot.
               if (gnt0_s || !P0_REQ) begin
                  state_r <= ST_ARB;
               end
            end
            default: begin
               state_r <= ST_ARB;
               cnt_r   <= 8'd0;
            end
         endcase
      end
   end

   // Read responses: one-cycle valid pulse, data held until the next response.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         p0_rvalid_r <= 1'b0;
         p1_rvalid_r <= 1'b0;
         p0_rdata_r  <= {DW{1'b0}};
         p1_rdata_r  <= {DW{1'b0}};
      end else begin
         p0_rvalid_r <= gnt0_s & ~P0_WE;
         p1_rvalid_r <= gnt1_s & ~P1_WE;
         if (gnt0_s && !P0_WE) begin
            p0_rdata_r <= ext_rdata(P0_TYPE, M_RDATA);
         end
         if (gnt1_s && !P1_WE) begin
            p1_rdata_r <= ext_rdata(P1_TYPE, M_RDATA);
         end
      end
   end

   assign P0_RVALID = p0_rvalid_r;
   assign P1_RVALID = p1_rvalid_r;
   assign P0_RDATA  = p0_rdata_r;
   assign P1_RDATA  = p1_rdata_r;

endmodule

// File: tb/tb_dtcm_arbiter.sv
// Directed bench for dtcm_arbiter with a small behavioural data memory.
module tb_dtcm_arbiter;

   logic        CLK;
   logic        RSTN;
   logic        P0_REQ, P0_WE, P1_REQ, P1_WE, P1_LOCK;
   logic [3:0]  P0_ADDR, P1_ADDR;
   logic [31:0] P0_WDATA, P1_WDATA;
   logic [2:0]  P0_TYPE, P1_TYPE;
   logic        P0_GNT, P1_GNT, P0_RVALID, P1_RVALID;
   logic [31:0] P0_RDATA, P1_RDATA;
   logic [3:0]  M_WADDR, M_RADDR;
   logic [31:0] M_WDATA, M_RDATA;
   logic        M_WEN, M_REN;
   logic [2:0]  M_RW_TYPE;

   logic [31:0] mem [0:15];
   int checks;
   int errors;

   dtcm_arbiter #(.AW(4), .DW(32), .LOCK_MAX(8)) dut (
      .CLK(CLK), .RSTN(RSTN),
      .P0_REQ(P0_REQ), .P0_WE(P0_WE), .P0_ADDR(P0_ADDR), .P0_WDATA(P0_WDATA), .P0_TYPE(P0_TYPE),
      .P1_REQ(P1_REQ), .P1_WE(P1_WE), .P1_ADDR(P1_ADDR), .P1_WDATA(P1_WDATA), .P1_TYPE(P1_TYPE),
      .P1_LOCK(P1_LOCK),
      .P0_GNT(P0_GNT), .P1_GNT(P1_GNT), .P0_RVALID(P0_RVALID), .P1_RVALID(P1_RVALID),
      .P0_RDATA(P0_RDATA), .P1_RDATA(P1_RDATA),
      .M_WADDR(M_WADDR), .M_RADDR(M_RADDR), .M_WDATA(M_WDATA), .M_WEN(M_WEN), .M_REN(M_REN),
      .M_RW_TYPE(M_RW_TYPE), .M_RDATA(M_RDATA)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Behavioural data memory: combinational read, typed write at the clock edge.
   assign M_RDATA = mem[M_RADDR];
   always @(posedge CLK) begin
      if (M_WEN) begin
         case (M_RW_TYPE)
            3'b000:  mem[M_WADDR][7:0]  <= M_WDATA[7:0];
            3'b001:  mem[M_WADDR][15:0] <= M_WDATA[15:0];
            3'b010:  mem[M_WADDR]       <= M_WDATA;
            default: ;
         endcase
      end
   end

   task automatic idle();
      P0_REQ = 1'b0; P0_WE = 1'b0; P0_ADDR = 4'd0; P0_WDATA = 32'd0; P0_TYPE = 3'b010;
      P1_REQ = 1'b0; P1_WE = 1'b0; P1_ADDR = 4'd0; P1_WDATA = 32'd0; P1_TYPE = 3'b010;
      P1_LOCK = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      RSTN = 1'b0;
      #1;
      checks++;
      if ({P0_RVALID, P1_RVALID, P0_GNT, P1_GNT, M_WEN, M_REN} !== 6'b000000) begin
         errors++;
         $display("FAIL reset_ctrl got %b exp 000000", {P0_RVALID, P1_RVALID, P0_GNT, P1_GNT, M_WEN, M_REN});
      end
      checks++;
      if ({P0_RDATA, P1_RDATA} !== 64'd0) begin
         errors++;
         $display("FAIL reset_rdata got %h %h exp 0 0", P0_RDATA, P1_RDATA);
      end
      @(negedge CLK);
      RSTN = 1'b1;
   endtask

   task automatic test_read_word();
      @(negedge CLK);
      P0_REQ = 1'b1; P0_ADDR = 4'd3; P0_TYPE = 3'b010;
      #1;
      checks++;
      if ({P0_GNT, P1_GNT, M_REN, M_WEN, M_RADDR} !== {4'b1010, 4'd3}) begin
         errors++;
         $display("FAIL read_grant got %b exp 1010_0011", {P0_GNT, P1_GNT, M_REN, M_WEN, M_RADDR});
      end
      @(posedge CLK); #1;
      checks++;
      if (P0_RVALID !== 1'b1 || P0_RDATA !== 32'h8000_80F0) begin
         errors++;
         $display("FAIL read_resp got %b %h exp 1 800080f0", P0_RVALID, P0_RDATA);
      end
      checks++;
      if (P1_RVALID !== 1'b0 || P1_RDATA !== 32'd0) begin
         errors++;
         $display("FAIL p1_quiet got %b %h exp 0 0", P1_RVALID, P1_RDATA);
      end
      @(negedge CLK);
      P0_REQ = 1'b0;
      @(posedge CLK); #1;
      checks++;
      if (P0_RVALID !== 1'b0 || P0_RDATA !== 32'h8000_80F0) begin
         errors++;
         $display("FAIL read_hold got %b %h exp 0 800080f0", P0_RVALID, P0_RDATA);
      end
   endtask

   task automatic test_read_ext();
      logic [2:0]  types [4];
      logic [31:0] exps  [4];
      types = '{3'b000, 3'b001, 3'b100, 3'b101};
      exps  = '{32'hFFFF_FFF0, 32'hFFFF_80F0, 32'h0000_00F0, 32'h0000_80F0};
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         P0_REQ = 1'b1; P0_ADDR = 4'd3; P0_TYPE = types[i];
         @(posedge CLK); #1;
         checks++;
         if (P0_RVALID !== 1'b1 || P0_RDATA !== exps[i]) begin
            errors++;
            $display("FAIL read_ext type %b got %b %h exp 1 %h", types[i], P0_RVALID, P0_RDATA, exps[i]);
         end
      end
      @(negedge CLK);
      idle();
   endtask

   task automatic test_alternate();
      RSTN = 1'b0;
      #1;
      RSTN = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         P0_REQ = 1'b1; P0_ADDR = 4'd3; P0_TYPE = 3'b010;
         P1_REQ = 1'b1; P1_ADDR = 4'd3; P1_TYPE = 3'b000;
         #1;
         checks++;
         if ({P0_GNT, P1_GNT} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL alt_grant cycle %0d got %b", i, {P0_GNT, P1_GNT});
         end
         @(posedge CLK); #1;
         checks++;
         if (i % 2 == 0) begin
            if ({P0_RVALID, P1_RVALID} !== 2'b10 || P0_RDATA !== 32'h8000_80F0) begin
               errors++;
               $display("FAIL alt_resp cycle %0d got %b %h exp 10 800080f0", i, {P0_RVALID, P1_RVALID}, P0_RDATA);
            end
         end else begin
            if ({P0_RVALID, P1_RVALID} !== 2'b01 || P1_RDATA !== 32'hFFFF_FFF0) begin
               errors++;
               $display("FAIL alt_resp cycle %0d got %b %h exp 01 fffffff0", i, {P0_RVALID, P1_RVALID}, P1_RDATA);
            end
         end
      end
      @(negedge CLK);
      idle();
   endtask

   task automatic test_lock();
      logic exp_p1;
      // Port 0 was granted last, so port 1 wins the first contended ARB cycle.
      for (int c = 0; c < 13; c++) begin
         @(negedge CLK);
         P0_REQ = 1'b1; P0_ADDR = 4'd3; P0_TYPE = 3'b010;
         P1_REQ = 1'b1; P1_ADDR = 4'd3; P1_TYPE = 3'b010;
         P1_LOCK = (c < 11);
         exp_p1 = !(c == 9 || c == 12);
         #1;
         checks++;
         if ({P0_GNT, P1_GNT} !== {~exp_p1, exp_p1}) begin
            errors++;
            $display("FAIL lock_grant cycle %0d got %b exp %b", c, {P0_GNT, P1_GNT}, {~exp_p1, exp_p1});
         end
      end
      @(negedge CLK);
      idle();
   endtask

   task automatic test_write_read();
      @(negedge CLK);
      P1_REQ = 1'b1; P1_WE = 1'b1; P1_ADDR = 4'd5; P1_WDATA = 32'h1234_5678; P1_TYPE = 3'b010;
      #1;
      checks++;
      if ({P1_GNT, M_WEN, M_REN, M_WADDR, M_WDATA} !== {3'b110, 4'd5, 32'h1234_5678}) begin
         errors++;
         $display("FAIL wr_bus got %b %h %h exp 110 5 12345678", {P1_GNT, M_WEN, M_REN}, M_WADDR, M_WDATA);
      end
      @(negedge CLK);
      P1_REQ = 1'b0; P1_WE = 1'b0;
      P0_REQ = 1'b1; P0_ADDR = 4'd5; P0_TYPE = 3'b010;
      #1;
      checks++;
      if (P1_RVALID !== 1'b0) begin
         errors++;
         $display("FAIL wr_no_rvalid got %b exp 0", P1_RVALID);
      end
      @(posedge CLK); #1;
      checks++;
      if (P0_RVALID !== 1'b1 || P0_RDATA !== 32'h1234_5678) begin
         errors++;
         $display("FAIL raw_read got %b %h exp 1 12345678", P0_RVALID, P0_RDATA);
      end
      @(negedge CLK);
      P0_WE = 1'b1; P0_WDATA = 32'hDEAD_BEEF; P0_TYPE = 3'b011;
      #1;
      checks++;
      if ({P0_GNT, M_WEN} !== 2'b11) begin
         errors++;
         $display("FAIL wr011_grant got %b exp 11", {P0_GNT, M_WEN});
      end
      @(negedge CLK);
      P0_WE = 1'b0; P0_TYPE = 3'b010;
      @(posedge CLK); #1;
      checks++;
      if (P0_RVALID !== 1'b1 || P0_RDATA !== 32'h1234_5678) begin
         errors++;
         $display("FAIL wr011_nochange got %b %h exp 1 12345678", P0_RVALID, P0_RDATA);
      end
      @(negedge CLK);
      idle();
   endtask

   task automatic test_reset_mid();
      @(negedge CLK);
      P0_REQ = 1'b1; P0_ADDR = 4'd3; P0_TYPE = 3'b010;
      P1_REQ = 1'b1; P1_ADDR = 4'd5; P1_TYPE = 3'b010; P1_LOCK = 1'b1;
      #1;
      checks++;
      if ({P0_GNT, P1_GNT} !== 2'b01) begin
         errors++;
         $display("FAIL mid_enter got %b exp 01", {P0_GNT, P1_GNT});
      end
      @(negedge CLK); #1;
      checks++;
      if ({P0_GNT, P1_GNT} !== 2'b01) begin
         errors++;
         $display("FAIL mid_locked got %b exp 01", {P0_GNT, P1_GNT});
      end
      @(posedge CLK); #1;
      checks++;
      if (P1_RVALID !== 1'b1 || P1_RDATA !== 32'h1234_5678) begin
         errors++;
         $display("FAIL mid_pending got %b %h exp 1 12345678", P1_RVALID, P1_RDATA);
      end
      #1;
      RSTN = 1'b0;
      #1;
      checks++;
      if (P1_RVALID !== 1'b0 || P1_RDATA !== 32'd0 || {P0_GNT, P1_GNT} !== 2'b10) begin
         errors++;
         $display("FAIL mid_reset got %b %h %b exp 0 0 10", P1_RVALID, P1_RDATA, {P0_GNT, P1_GNT});
      end
      @(negedge CLK);
      RSTN = 1'b1;
      #1;
      checks++;
      if ({P0_GNT, P1_GNT} !== 2'b10) begin
         errors++;
         $display("FAIL mid_release got %b exp 10", {P0_GNT, P1_GNT});
      end
      @(posedge CLK); #1;
      checks++;
      if ({P0_RVALID, P1_RVALID} !== 2'b10 || P0_RDATA !== 32'h8000_80F0) begin
         errors++;
         $display("FAIL mid_after got %b %h exp 10 800080f0", {P0_RVALID, P1_RVALID}, P0_RDATA);
      end
      @(negedge CLK);
      idle();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      for (int i = 0; i < 16; i++) mem[i] = 32'd0;
      mem[3] = 32'h8000_80F0;
      test_reset();
      test_read_word();
      test_read_ext();
      test_alternate();
      test_lock();
      test_write_read();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
